brick_wall: RTL and testbench
=============================

# brick_wall

Brick field for the Breakout game. Holds one alive bit per brick and tells the colour logic which pixels belong to a live brick. Once per video frame it checks the ball against the field, clears at most one brick, and reports the hit and the bounce axis. It sits alongside the ball mover and the score block: it consumes the VGA scan coordinates and the ball centre, and feeds a hit pulse to scoring and bounce requests to the ball mover.

## Interface
Parameters:
- ROWS, 4: brick rows.
- COLS, 10: brick columns; COLS*BRICK_W = 640.
- BRICK_W, 64: brick width in px; power of two.
- BRICK_H, 16: brick height in px; power of two.
- TOP_Y, 48: y of the first brick row.
- GAP, 2: unpainted px at the left and top edge of each cell.
- R_BALL, 8: ball radius.

Ports:
- clock  in  1  pixel clock (VGA_CLK domain)
- reset  in  1  asynchronous, active-low; one clock, no other clocks
- start  in  1  level input; a rising edge restores all bricks
- frame  in  1  one-cycle pulse at start of vertical blank
- next_x, next_y  in  10 each  scan coordinate from the vga block
- x_ball, y_ball  in  10 each  ball centre
- brick_pixel  out  1  combinational: (next_x,next_y) lies on a live brick, outside the GAP margin
- brick_row  out  2  combinational: row of that pixel, used for colour
- hit_brick  out  1  one-cycle pulse when a brick is destroyed
- bounce_x, bounce_y  out  1 each  coincident with hit_brick; indicate the axis to reverse
- bricks_left  out  7  count of live bricks
- cleared  out  1  registered; high when bricks_left == 0

## Operation
- Wall region: y in [TOP_Y, TOP_Y+ROWS*BRICK_H) and x in [0,640).
  - col = x >> log2(BRICK_W).
  - row = (y-TOP_Y) >> log2(BRICK_H).
- All point arithmetic is 11-bit signed. A negative coordinate or a point outside the wall region never hits.
- Reset value: all alive bits 1, bricks_left = ROWS*COLS (40), cleared 0, hit_brick/bounce_x/bounce_y 0, state IDLE.
- Restore: start is registered for edge detection. On a rising edge, all alive bits are set to 1, bricks_left is set to 40, and the FSM is forced to IDLE with no pulse. Holding start high does not restore again.
- FSM: IDLE → CHECK_TOP → CHECK_BOTTOM → CHECK_LEFT → CHECK_RIGHT → IDLE.
  - IDLE leaves only on frame.
  - Each check state tests one extreme point through the shared lookup:
    - top point: (x_ball, y_ball−R_BALL)
    - bottom point: (x_ball, y_ball+R_BALL)
    - left point: (x_ball−R_BALL, y_ball)
    - right point: (x_ball+R_BALL, y_ball)
  - On a hit (point inside the region and its alive bit is 1):
    - the alive bit is cleared and bricks_left is decremented at that edge;
    - the FSM goes to REPORT.
  - CHECK_RIGHT with no hit returns to IDLE.
  - REPORT: hit_brick = 1 for one cycle. bounce_y = 1 if the hit came from TOP/BOTTOM, bounce_x = 1 if from LEFT/RIGHT. Then IDLE.
- At most one brick is cleared per frame. Priority is TOP > BOTTOM > LEFT > RIGHT.
- frame arriving while not in IDLE is ignored.
- Ball inputs are sampled in each check state; they are not latched at frame.

## Timing
- frame sampled at edge k:
  - hit in TOP → REPORT during cycle k+2;
  - hit in BOTTOM → k+3;
  - hit in LEFT → k+4;
  - hit in RIGHT → k+5.
- brick_pixel and bricks_left reflect the cleared brick from the cycle after the check edge, i.e. during REPORT.
- cleared follows bricks_left with 1-cycle latency.
- brick_pixel has zero latency, so it aligns with the bar/ball flags entering the colour register.
- Reset asserted mid-check: immediate IDLE with no pulse, all alive bits 1.

## Structure
- Shared package breakout_pkg holds:
  - screen limits 640/480;
  - ball/bar/brick geometry constants, ROWS, COLS;
  - the state enum for IDLE, CHECK_TOP, CHECK_BOTTOM, CHECK_LEFT, CHECK_RIGHT, REPORT.
- Sub-module brick_cell_lookup: combinational; maps (x,y) to {inside, row, col, in_gap}.
  - Instantiated twice: once for the pixel path, once for the time-multiplexed check point.

## Test plan
- Reset released:
  - (next_x,next_y) = (100,50) → brick_pixel = 1, brick_row = 0.
  - (64,50) → brick_pixel = 0 (gap).
  - bricks_left = 40.
- Ball (96,118), frame:
  - hit_brick and bounce_y during k+2; bricks_left = 39.
  - brick_pixel at (96,104) = 0 (row 3, col 1 cleared).
- Then ball (120,104), frame:
  - top point row 3 col 1 is dead and the bottom point is outside the wall, so no vertical hit.
  - bounce_x at k+5; row 3 col 2 cleared; bricks_left = 38.
- Ball (50,300), frame → no hit_brick for 6 cycles; bricks_left unchanged.
- Clear bricks, then raise start and hold it:
  - bricks_left = 40 the next cycle and all bricks are painted again.
  - A second frame with start still high does not trigger another restore.
  - After all 40 bricks are destroyed, cleared = 1.
- Assert reset during CHECK_LEFT:
  - no hit_brick;
  - bricks_left = 40;
  - state IDLE after release.

Source files
------------

// File: rtl/breakout_pkg.sv
// Breakout geometry shared by the game blocks, plus the brick-wall FSM states.
package breakout_pkg;

   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;

   localparam int BALL_R      = 8;
   localparam int BAR_W       = 64;
   localparam int BAR_H       = 8;

   localparam int BRICK_ROWS  = 4;
   localparam int BRICK_COLS  = 10;
   localparam int BRICK_WIDTH = 64;
   localparam int BRICK_HIGHT = 16;
   localparam int WALL_TOP_Y  = 48;
   localparam int BRICK_GAP   = 2;

   typedef enum logic [2:0] {
      IDLE,
      CHECK_TOP,
      CHECK_BOTTOM,
      CHECK_LEFT,
      CHECK_RIGHT,
      REPORT
   } wall_state_t;

   // Unsigned 10-bit screen coordinate widened to the signed 11-bit point domain.
   function automatic logic signed [10:0] to_s11(input logic [9:0] v);
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/brick_wall_if.sv
// Signals between the brick wall and its neighbours (vga scan, ball mover, score).
interface brick_wall_if;
   logic       start;
   logic       frame;
   logic [9:0] next_x;
   logic [9:0] next_y;
   logic [9:0] x_ball;
   logic [9:0] y_ball;
   logic       brick_pixel;
   logic [1:0] brick_row;
   logic       hit_brick;
   logic       bounce_x;
   logic       bounce_y;
   logic [6:0] bricks_left;
   logic       cleared;

   modport master (
      output start, frame, next_x, next_y, x_ball, y_ball,
      input  brick_pixel, brick_row, hit_brick, bounce_x, bounce_y, bricks_left, cleared
   );

   modport slave (
      input  start, frame, next_x, next_y, x_ball, y_ball,
      output brick_pixel, brick_row, hit_brick, bounce_x, bounce_y, bricks_left, cleared
   );
endinterface

// File: rtl/brick_cell_lookup.sv
// Maps a signed point to its brick cell: inside-wall flag, row, column, and
// whether it falls in the unpainted margin at the cell's left/top edge.
module brick_cell_lookup #(
   parameter  int ROWS    = 4,
   parameter  int COLS    = 10,
   parameter  int BRICK_W = 64,
   parameter  int BRICK_H = 16,
   parameter  int TOP_Y   = 48,
   parameter  int GAP     = 2,
   localparam int RW      = $clog2(ROWS),
   localparam int CW      = $clog2(COLS)
) (
   input  logic signed [10:0] x_i,
   input  logic signed [10:0] y_i,
   output logic               inside_o,
   output logic [RW-1:0]      row_o,
   output logic [CW-1:0]      col_o,
   output logic               in_gap_o
);

   localparam int XS = $clog2(BRICK_W);
   localparam int YS = $clog2(BRICK_H);

   localparam logic signed [10:0] X_END = 11'(COLS * BRICK_W);
   localparam logic signed [10:0] Y_BEG = 11'(TOP_Y);
   localparam logic signed [10:0] Y_END = 11'(TOP_Y + ROWS * BRICK_H);
   localparam logic [XS-1:0]      GAP_X = XS'(GAP);
   localparam logic [YS-1:0]      GAP_Y = YS'(GAP);

   // Offset into the wall; only meaningful when inside_o is high.
   logic [10:0] dy;
   assign dy = y_i - Y_BEG;

   assign inside_o = (x_i >= 11'sd0) && (x_i < X_END) && (y_i >= Y_BEG) && (y_i < Y_END);
   assign col_o    = CW'(x_i[10:XS]);
   assign row_o    = RW'(dy[10:YS]);
   assign in_gap_o = (x_i[XS-1:0] < GAP_X) || (dy[YS-1:0] < GAP_Y);

endmodule

// File: rtl/brick_wall.sv
// Breakout brick field: paints live bricks for the scan position and, once per
// frame, tests the four extreme ball points in priority order, clearing one brick.
module brick_wall
   import breakout_pkg::*;
#(
   parameter int ROWS    = BRICK_ROWS,
   parameter int COLS    = BRICK_COLS,
   parameter int BRICK_W = BRICK_WIDTH,
   parameter int BRICK_H = BRICK_HIGHT,
   parameter int TOP_Y   = WALL_TOP_Y,
   parameter int GAP     = BRICK_GAP,
   parameter int R_BALL  = BALL_R
) (
   input logic         clock,
   input logic         reset,
   brick_wall_if.slave bus
);

   localparam int N  = ROWS * COLS;
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   localparam logic [6:0]         FULL = 7'(N);
   localparam logic signed [10:0] R_S  = 11'(R_BALL);

   wall_state_t  state_q;
   logic [N-1:0] alive_q;
   logic [6:0]   left_q;
   logic         start_q;
   logic         hit_q;
   logic         bx_q;
   logic         by_q;
   logic         cleared_q;

   logic                pix_inside, pix_gap;
   logic [RW-1:0]       pix_row;
   logic [CW-1:0]       pix_col;
   logic                chk_inside, chk_gap;
   logic [RW-1:0]       chk_row;
   logic [CW-1:0]       chk_col;
   logic signed [10:0]  ball_x, ball_y, chk_x, chk_y;
   logic                is_check;
   logic [N-1:0]        pix_sel, chk_sel;
   logic                chk_hit, start_rise;

   brick_cell_lookup #(
      .ROWS(ROWS), .COLS(COLS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H), .TOP_Y(TOP_Y), .GAP(GAP)
   ) u_pix_lookup (
      .x_i      (to_s11(bus.next_x)),
      .y_i      (to_s11(bus.next_y)),
      .inside_o (pix_inside),
      .row_o    (pix_row),
      .col_o    (pix_col),
      .in_gap_o (pix_gap)
   );

   brick_cell_lookup #(
      .ROWS(ROWS), .COLS(COLS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H), .TOP_Y(TOP_Y), .GAP(GAP)
   ) u_chk_lookup (
      .x_i      (chk_x),
      .y_i      (chk_y),
      .inside_o (chk_inside),
      .row_o    (chk_row),
      .col_o    (chk_col),
      .in_gap_o (chk_gap)
   );

   assign ball_x = to_s11(bus.x_ball);
   assign ball_y = to_s11(bus.y_ball);

   // The check lookup is time-shared: the state picks which extreme point it sees.
   always_comb begin
      chk_x    = ball_x;
      chk_y    = ball_y;
      is_check = 1'b1;
      case (state_q)
         CHECK_TOP:    chk_y = ball_y - R_S;
         CHECK_BOTTOM: chk_y = ball_y + R_S;
         CHECK_LEFT:   chk_x = ball_x - R_S;
         CHECK_RIGHT:  chk_x = ball_x + R_S;
         default:      is_check = 1'b0;
      endcase
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_cell
      localparam logic [RW-1:0] GR = RW'(gi / COLS);
      localparam logic [CW-1:0] GC = CW'(gi % COLS);
      assign pix_sel[gi] = alive_q[gi] && (pix_row == GR) && (pix_col == GC);
      assign chk_sel[gi] = alive_q[gi] && (chk_row == GR) && (chk_col == GC);
   end

   // The gap margin is purely cosmetic; a ball point in it still hits the brick.
   assign chk_hit    = is_check && chk_inside && (|chk_sel);
   assign start_rise = bus.start && !start_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         alive_q   <= '1;
         left_q    <= FULL;
         start_q   <= 1'b0;
         hit_q     <= 1'b0;
         bx_q      <= 1'b0;
         by_q      <= 1'b0;
         cleared_q <= 1'b0;
      end else begin
         start_q   <= bus.start;
         hit_q     <= 1'b0;
         bx_q      <= 1'b0;
         by_q      <= 1'b0;
         cleared_q <= (left_q == 7'd0);
         if (start_rise) begin
            alive_q <= '1;
            left_q  <= FULL;
            state_q <= IDLE;
         end else if (chk_hit) begin
            alive_q <= alive_q & ~chk_sel;
            left_q  <= left_q - 7'd1;
            hit_q   <= 1'b1;
            by_q    <= (state_q == CHECK_TOP) || (state_q == CHECK_BOTTOM);
            bx_q    <= (state_q == CHECK_LEFT) || (state_q == CHECK_RIGHT);
            state_q <= REPORT;
         end else begin
            case (state_q)
               IDLE:         if (bus.frame) state_q <= CHECK_TOP;
               CHECK_TOP:    state_q <= CHECK_BOTTOM;
               CHECK_BOTTOM: state_q <= CHECK_LEFT;
               CHECK_LEFT:   state_q <= CHECK_RIGHT;
               default:      state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.brick_pixel = pix_inside && !pix_gap && (|pix_sel);
   assign bus.brick_row   = 2'(pix_row);
   assign bus.hit_brick   = hit_q;
   assign bus.bounce_x    = bx_q;
   assign bus.bounce_y    = by_q;
   assign bus.bricks_left = left_q;
   assign bus.cleared     = cleared_q;

endmodule

// File: tb/tb_brick_wall.sv
// Directed bench for brick_wall: a queue of expected hit reports is checked by a
// monitor whenever hit_brick is seen; pixel and counter checks are made inline.
module tb_brick_wall;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   brick_wall_if bus();

   brick_wall #(
      .ROWS(4), .COLS(10), .BRICK_W(64), .BRICK_H(16), .TOP_Y(48), .GAP(2), .R_BALL(8)
   ) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int lat;
      bit bx;
      bit by;
      int left;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   checks    = 0;
   int   passes    = 0;
   int   cyc       = 0;
   int   frame_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   // Latency counts from the edge that samples frame to the edge that samples hit_brick.
   always @(negedge clk) begin
      if (rst_n && bus.hit_brick) begin
         if (expq.size() == 0) begin
            check("unexpected_hit", 1, 0);
         end else begin
            mon_e = expq.pop_front();
            $display("hit: latency=%0d bounce_x=%0d bounce_y=%0d bricks_left=%0d",
                     cyc + 1 - frame_cyc, bus.bounce_x, bus.bounce_y, bus.bricks_left);
            check("hit_latency", cyc + 1 - frame_cyc, mon_e.lat);
            check("bounce_x", int'(bus.bounce_x), int'(mon_e.bx));
            check("bounce_y", int'(bus.bounce_y), int'(mon_e.by));
            check("bricks_left_at_hit", int'(bus.bricks_left), mon_e.left);
         end
      end
   end

   task automatic pix(input int x, input int y, input int exp_p, input int exp_row);
      bus.next_x = 10'(x);
      bus.next_y = 10'(y);
      #1;
      check($sformatf("brick_pixel(%0d,%0d)", x, y), int'(bus.brick_pixel), exp_p);
      if (exp_p == 1) check($sformatf("brick_row(%0d,%0d)", x, y), int'(bus.brick_row), exp_row);
   endtask

   // lat == 0 means no hit expected in this frame.
   task automatic fire(input int bx, input int by, input int lat, input bit ex, input bit ey,
                       input int left, input bit refire);
      bus.x_ball = 10'(bx);
      bus.y_ball = 10'(by);
      if (lat != 0) expq.push_back('{lat, ex, ey, left});
      @(negedge clk);
      bus.frame = 1'b1;
      frame_cyc = cyc + 1;
      @(negedge clk);
      bus.frame = 1'b0;
      if (refire) begin
         bus.frame = 1'b1;
         @(negedge clk);
         bus.frame = 1'b0;
      end
      repeat (7) @(negedge clk);
      check($sformatf("expected_hits_seen(%0d,%0d)", bx, by), expq.size(), 0);
      expq.delete();
   endtask

   initial begin
      int left;
      bus.start  = 1'b0;
      bus.frame  = 1'b0;
      bus.next_x = 10'd0;
      bus.next_y = 10'd0;
      bus.x_ball = 10'd320;
      bus.y_ball = 10'd400;

      repeat (3) @(negedge clk);
      check("reset_bricks_left", int'(bus.bricks_left), 40);
      check("reset_cleared", int'(bus.cleared), 0);
      check("reset_hit", int'(bus.hit_brick), 0);
      rst_n = 1'b1;
      @(negedge clk);

      pix(100, 50, 1, 0);
      pix(64, 50, 0, 0);
      pix(65, 50, 0, 0);
      pix(66, 50, 1, 0);
      pix(100, 49, 0, 0);
      pix(100, 47, 0, 0);
      pix(639, 111, 1, 3);
      pix(100, 112, 0, 0);
      pix(310, 75, 1, 1);
      check("bricks_left_after_release", int'(bus.bricks_left), 40);

      // Top point (96,110): row 3, col 1.
      fire(96, 118, 2, 1'b0, 1'b1, 39, 1'b0);
      pix(96, 104, 0, 0);
      pix(150, 104, 1, 3);
      // Top and left land on the dead brick, bottom is below the wall: right hits row 3 col 2.
      fire(120, 104, 5, 1'b1, 1'b0, 38, 1'b0);
      pix(150, 104, 0, 0);
      fire(50, 300, 0, 1'b0, 1'b0, 0, 1'b0);
      check("bricks_left_no_hit", int'(bus.bricks_left), 38);
      // Top (row 0) and bottom (row 1) both live in col 4: top wins.
      fire(300, 64, 2, 1'b0, 1'b1, 37, 1'b0);
      pix(310, 55, 0, 0);
      pix(310, 75, 1, 1);
      // Top above the wall, bottom hits row 0 col 6.
      fire(400, 40, 3, 1'b0, 1'b1, 36, 1'b0);
      pix(400, 55, 0, 0);
      // Bottom on dead row 0 col 4, left hits row 0 col 3; a second frame mid-check is ignored.
      fire(260, 52, 4, 1'b1, 1'b0, 35, 1'b1);
      check("cleared_while_bricks_left", int'(bus.cleared), 0);

      // Restore on a rising start and keep start high.
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      check("restore_bricks_left", int'(bus.bricks_left), 40);
      pix(96, 104, 1, 3);
      pix(400, 55, 1, 0);
      pix(310, 55, 1, 0);

      fire(96, 118, 2, 1'b0, 1'b1, 39, 1'b0);
      check("no_second_restore", int'(bus.bricks_left), 39);
      left = 39;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 10; c++) begin
            if (!(r == 3 && c == 1)) begin
               left--;
               fire(c * 64 + 32, 48 + r * 16 + 16, 2, 1'b0, 1'b1, left, 1'b0);
            end
         end
      end
      repeat (2) @(negedge clk);
      check("all_cleared_bricks_left", int'(bus.bricks_left), 0);
      check("all_cleared_flag", int'(bus.cleared), 1);
      pix(100, 50, 0, 0);

      // Fresh wall, one brick down, then reset during CHECK_LEFT.
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      repeat (2) @(negedge clk);
      check("cleared_after_restore", int'(bus.cleared), 0);
      bus.start = 1'b0;
      fire(96, 118, 2, 1'b0, 1'b1, 39, 1'b0);
      bus.x_ball = 10'd644;
      bus.y_ball = 10'd60;
      @(negedge clk);
      bus.frame = 1'b1;
      frame_cyc = cyc + 1;
      @(negedge clk);
      bus.frame = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_mid_check_bricks_left", int'(bus.bricks_left), 40);
      check("reset_mid_check_hit", int'(bus.hit_brick), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      pix(96, 104, 1, 3);
      pix(620, 60, 1, 0);
      // A top hit at the usual latency shows the FSM came back in IDLE.
      fire(96, 118, 2, 1'b0, 1'b1, 39, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
